// File: rtl/img_line_buffer.sv
// Raster-to-column front end: keeps the last K_H-1 image rows on chip and emits one
// vertical K_H-pixel column per accepted pixel, tagging loads that complete a K_H x K_W window.
module img_line_buffer #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int K_H   = 3,
  parameter int K_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pix_valid,
  input  logic [7:0]               pix_data,
  output logic                     pix_ready,
  output logic [0:K_H-1][7:0]      col_data,
  output logic                     load_en,
  output logic                     clear,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(K_H - 1);
  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K_W - 1);

  logic [2:0]          state_reg, state_next;
  logic [RW-1:0]       row_reg, row_next;
  logic [CW-1:0]       col_reg, col_next;
  logic                accept;

  logic [0:K_H-1][7:0] col_data_reg;
  logic                load_en_reg;
  logic                win_valid_reg;
  logic [RW-1:0]       win_row_reg;
  logic [CW-1:0]       win_col_reg;

  // lb_mem[0] holds the oldest buffered row, lb_mem[K_H-2] the previous row.
  logic [7:0] lb_mem [0:K_H-2][0:IMG_W-1];
  logic [7:0] lb_rd  [0:K_H-2];

  assign accept = pix_valid && (state_reg == S_RUN);

  genvar gi;
  generate
    for (gi = 0; gi < K_H - 1; gi++) begin : g_rd
      assign lb_rd[gi] = lb_mem[gi][col_reg];
    end
  endgenerate

  // Row advance happens in DRAIN, so DRAIN still sees the row just finished.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLR;
          row_next   = '0;
          col_next   = '0;
        end
      end
      S_CLR: state_next = S_RUN;
      S_RUN: begin
        if (accept) begin
          if (col_reg == COL_LAST) begin
            col_next   = '0;
            state_next = S_DRAIN;
          end else begin
            col_next = col_reg + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (row_reg == ROW_LAST) begin
          state_next = S_DONE;
        end else begin
          row_next   = row_reg + 1'b1;
          state_next = S_CLR;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
    end
  end

  // Line buffers are deliberately unreset: the first K_H-1 rows overwrite every entry.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < K_H - 2; k++) begin
        lb_mem[k][col_reg] <= lb_mem[k+1][col_reg];
      end
      lb_mem[K_H-2][col_reg] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_data_reg  <= '0;
      load_en_reg   <= 1'b0;
      win_valid_reg <= 1'b0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
    end else begin
      load_en_reg   <= accept && (row_reg >= ROW_FIRST_OUT);
      win_valid_reg <= accept && (row_reg >= ROW_FIRST_OUT) && (col_reg >= COL_FIRST_WIN);
      if (accept) begin
        for (int k = 0; k < K_H - 1; k++) begin
          col_data_reg[k] <= lb_rd[k];
        end
        col_data_reg[K_H-1] <= pix_data;
        win_row_reg         <= row_reg - ROW_FIRST_OUT;
        win_col_reg         <= col_reg - COL_FIRST_WIN;
      end
    end
  end

  assign pix_ready  = (state_reg == S_RUN);
  assign clear      = (state_reg == S_CLR);
  assign frame_done = (state_reg == S_DONE);
  assign busy       = (state_reg != S_IDLE);
  assign col_data   = col_data_reg;
  assign load_en    = load_en_reg;
  assign win_valid  = win_valid_reg;
  assign win_row    = win_row_reg;
  assign win_col    = win_col_reg;

endmodule

// File: tb/tb_img_line_buffer.sv
// Directed bench for img_line_buffer: a 5x4 instance for timing/boundary cases and a
// default 28x28 instance for the full-frame window count.
module tb_img_line_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start_s = 1'b0;
  logic       start_b = 1'b0;
  logic       pix_valid = 1'b0;
  logic [7:0] pix_data = 8'h00;
  logic       sel_big = 1'b0;

  logic             s_pix_ready, s_load_en, s_clear, s_win_valid, s_busy, s_frame_done;
  logic [0:2][7:0]  s_col_data;
  logic [1:0]       s_win_row;
  logic [2:0]       s_win_col;

  logic             b_pix_ready, b_load_en, b_clear, b_win_valid, b_busy, b_frame_done;
  logic [0:2][7:0]  b_col_data;
  logic [4:0]       b_win_row;
  logic [4:0]       b_win_col;

  img_line_buffer #(.IMG_W(5), .IMG_H(4), .K_H(3), .K_W(3)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(s_pix_ready), .col_data(s_col_data), .load_en(s_load_en), .clear(s_clear),
    .win_valid(s_win_valid), .win_row(s_win_row), .win_col(s_win_col), .busy(s_busy),
    .frame_done(s_frame_done)
  );

  img_line_buffer dut_b (
    .clk(clk), .rst(rst), .start(start_b), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(b_pix_ready), .col_data(b_col_data), .load_en(b_load_en), .clear(b_clear),
    .win_valid(b_win_valid), .win_row(b_win_row), .win_col(b_win_col), .busy(b_busy),
    .frame_done(b_frame_done)
  );

  logic        m_pix_ready, m_load_en, m_clear, m_win_valid, m_busy, m_frame_done;
  logic [23:0] m_col;
  int          m_wrow, m_wcol;

  assign m_pix_ready  = sel_big ? b_pix_ready  : s_pix_ready;
  assign m_load_en    = sel_big ? b_load_en    : s_load_en;
  assign m_clear      = sel_big ? b_clear      : s_clear;
  assign m_win_valid  = sel_big ? b_win_valid  : s_win_valid;
  assign m_busy       = sel_big ? b_busy       : s_busy;
  assign m_frame_done = sel_big ? b_frame_done : s_frame_done;
  assign m_col        = sel_big ? b_col_data   : s_col_data;
  assign m_wrow       = sel_big ? int'(b_win_row) : int'(s_win_row);
  assign m_wcol       = sel_big ? int'(b_win_col) : int'(s_win_col);

  int checks = 0;
  int errors = 0;

  logic [23:0] col_q[$];
  int          wr_q[$];
  int          wc_q[$];
  int          n_overlap = 0;

  always @(negedge clk) begin
    if (m_load_en) col_q.push_back(m_col);
    if (m_win_valid) begin
      wr_q.push_back(m_wrow);
      wc_q.push_back(m_wcol);
    end
    if (m_load_en && m_clear) n_overlap++;
  end

  function automatic logic [7:0] pix(input int r, input int c, input int seed);
    return 8'((16 * r + c + seed) & 255);
  endfunction

  task automatic set_start(input logic v);
    if (sel_big) start_b = v;
    else start_s = v;
  endtask

  task automatic do_start();
    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
  endtask

  // Streams pixels of one frame; every cycle checks load_en/win_valid against the accept history.
  task automatic stream(input int w, input int h, input int seed, input int gap,
                        input int start_at, input int stop_after, input bit chk_bound);
    int r = 0;
    int c = 0;
    int n = 0;
    int guard = 0;
    bit acc;
    bit exp_load;
    bit exp_win;
    while (r < h && n != stop_after) begin
      pix_valid = ($urandom_range(0, 99) >= gap);
      pix_data  = pix(r, c, seed);
      set_start(n == start_at);
      #1 acc = pix_valid && m_pix_ready;
      @(negedge clk);
      guard++;
      exp_load = acc && (r >= 2);
      exp_win  = exp_load && (c >= 2);
      checks++;
      if (m_load_en !== exp_load) begin
        errors++;
        $display("FAIL load_en r=%0d c=%0d got %0b want %0b", r, c, m_load_en, exp_load);
      end
      checks++;
      if (m_win_valid !== exp_win) begin
        errors++;
        $display("FAIL win_valid r=%0d c=%0d got %0b want %0b", r, c, m_win_valid, exp_win);
      end
      if (acc) begin
        n++;
        if (c == w - 1) begin
          c = 0;
          checks++;
          if (m_pix_ready !== 1'b0) begin
            errors++;
            $display("FAIL drain_ready r=%0d got %0b want 0", r, m_pix_ready);
          end
          if (r == h - 1) begin
            pix_valid = 1'b0;
            set_start(1'b0);
            @(negedge clk);
            checks++;
            if (m_frame_done !== 1'b1) begin
              errors++;
              $display("FAIL frame_done_latency got %0b want 1", m_frame_done);
            end
            @(negedge clk);
            checks++;
            if (m_busy !== 1'b0 || m_frame_done !== 1'b0) begin
              errors++;
              $display("FAIL idle_after_done busy=%0b done=%0b want 0 0", m_busy, m_frame_done);
            end
          end else if (chk_bound) begin
            pix_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (m_pix_ready !== 1'b0 || m_clear !== 1'b1 || m_load_en !== 1'b0) begin
              errors++;
              $display("FAIL clr_cycle r=%0d ready=%0b clear=%0b load=%0b want 0 1 0",
                       r, m_pix_ready, m_clear, m_load_en);
            end
            @(negedge clk);
            checks++;
            if (m_pix_ready !== 1'b1 || m_clear !== 1'b0 || m_load_en !== 1'b0) begin
              errors++;
              $display("FAIL run_again r=%0d ready=%0b clear=%0b load=%0b want 1 0 0",
                       r, m_pix_ready, m_clear, m_load_en);
            end
          end
          r++;
        end else begin
          c++;
        end
      end
      if (guard > 5000) begin
        errors++;
        $display("FAIL stream_timeout accepted=%0d want %0d", n, w * h);
        break;
      end
    end
    pix_valid = 1'b0;
    set_start(1'b0);
  endtask

  task automatic check_frame(input string tag, input int w, input int h, input int seed,
                             input int bl, input int bw);
    int i = bl;
    int j = bw;
    logic [23:0] e;
    checks++;
    if (col_q.size() - bl != (h - 2) * w) begin
      errors++;
      $display("FAIL %s load_count got %0d want %0d", tag, col_q.size() - bl, (h - 2) * w);
    end
    checks++;
    if (wr_q.size() - bw != (h - 2) * (w - 2)) begin
      errors++;
      $display("FAIL %s win_count got %0d want %0d", tag, wr_q.size() - bw, (h - 2) * (w - 2));
    end
    checks++;
    if (n_overlap != 0) begin
      errors++;
      $display("FAIL %s clear_load_overlap got %0d want 0", tag, n_overlap);
    end
    for (int r = 2; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e = {pix(r - 2, c, seed), pix(r - 1, c, seed), pix(r, c, seed)};
        if (i < col_q.size()) begin
          checks++;
          if (col_q[i] !== e) begin
            errors++;
            $display("FAIL %s col_data r=%0d c=%0d got %06h want %06h", tag, r, c, col_q[i], e);
          end
        end
        i++;
        if (c >= 2) begin
          if (j < wr_q.size()) begin
            checks++;
            if (wr_q[j] != r - 2 || wc_q[j] != c - 2) begin
              errors++;
              $display("FAIL %s win_pos got (%0d,%0d) want (%0d,%0d)", tag, wr_q[j], wc_q[j], r - 2, c - 2);
            end
          end
          j++;
        end
      end
    end
    $display("frame %s: loads=%0d windows=%0d", tag, col_q.size() - bl, wr_q.size() - bw);
  endtask

  task automatic run_frame(input string tag, input int w, input int h, input int seed,
                           input int gap, input int start_at, input bit chk_bound);
    int bl = col_q.size();
    int bw = wr_q.size();
    do_start();
    stream(w, h, seed, gap, start_at, -1, chk_bound);
    check_frame(tag, w, h, seed, bl, bw);
  endtask

  task automatic check_reset_values(input string tag);
    checks++;
    if (m_pix_ready !== 1'b0 || m_load_en !== 1'b0 || m_clear !== 1'b0 || m_win_valid !== 1'b0 ||
        m_busy !== 1'b0 || m_frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s ctrl ready=%0b load=%0b clear=%0b win=%0b busy=%0b done=%0b want all 0",
               tag, m_pix_ready, m_load_en, m_clear, m_win_valid, m_busy, m_frame_done);
    end
    checks++;
    if (m_col !== 24'h0 || m_wrow != 0 || m_wcol != 0) begin
      errors++;
      $display("FAIL %s data col=%06h row=%0d col=%0d want 0 0 0", tag, m_col, m_wrow, m_wcol);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    pix_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_pix_ready !== 1'b0 || m_load_en !== 1'b0 || m_busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_no_accept ready=%0b load=%0b busy=%0b want 0 0 0",
                 m_pix_ready, m_load_en, m_busy);
      end
    end
    pix_valid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    run_frame("back_to_back", 5, 4, 0, 0, -1, 1'b1);
  endtask

  task automatic test_gaps();
    run_frame("gaps", 5, 4, 0, 50, -1, 1'b0);
  endtask

  task automatic test_start_ignored();
    run_frame("start_ignored", 5, 4, 3, 0, 7, 1'b0);
  endtask

  task automatic test_rst_midframe();
    do_start();
    stream(5, 4, 50, 0, -1, 9, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst_midframe");
    rst = 1'b0;
    run_frame("after_rst", 5, 4, 100, 0, -1, 1'b0);
  endtask

  task automatic test_default_params();
    logic [23:0] e;
    sel_big = 1'b1;
    run_frame("default_28x28", 28, 28, 0, 0, -1, 1'b0);
    e = {pix(25, 27, 0), pix(26, 27, 0), pix(27, 27, 0)};
    checks++;
    if (col_q.size() == 0 || wr_q.size() == 0) begin
      errors++;
      $display("FAIL last_window empty queues got %0d want >0", col_q.size());
    end else if (wr_q[$] != 25 || wc_q[$] != 25 || col_q[$] !== e) begin
      errors++;
      $display("FAIL last_window got (%0d,%0d) %06h want (25,25) %06h", wr_q[$], wc_q[$], col_q[$], e);
    end
    sel_big = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps();
    test_start_ignored();
    test_rst_midframe();
    test_default_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/img_line_buffer.md
# img_line_buffer

Raster-to-column front end for the convolution window path. Accepts a frame of 8-bit pixels in row-major order over a valid/ready stream and stores the last K_H-1 rows in on-chip line buffers. For every accepted pixel from row K_H-1 onward, it emits one vertical K_H-pixel column with a load strobe, directly driving the downstream circular image register (`in_data` / `load_en` / `clear`). It also flags cycles where that register holds a complete K_H×K_W window.

## Interface
- IMG_W, 28, pixels per row (≥ K_W)
- IMG_H, 28, rows per frame (≥ K_H)
- K_H, 3, window height = column length (≥ 2)
- K_W, 3, window width, used only for window tagging
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle frame-start pulse; ignored unless in IDLE
- pix_valid  in  1  pix_data valid
- pix_data  in  8  pixel, unsigned
- pix_ready  out  1  block can accept a pixel this cycle
- col_data  out  8 × [0:K_H-1]  column; [0] = oldest row, [K_H-1] = current row
- load_en  out  1  col_data valid; shift into window register
- clear  out  1  zero the window register
- win_valid  out  1  with load_en: window register holds a full window after this load
- win_row  out  $clog2(IMG_H)  top row of the window, valid with win_valid
- win_col  out  $clog2(IMG_W)  left column of the window, valid with win_valid
- busy  out  1  not IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, CLR, RUN, DRAIN, DONE. pix_ready = (state == RUN). clear = (state == CLR). frame_done = (state == DONE). busy = (state != IDLE).
- Transitions:
  - IDLE → CLR on start.
  - CLR → RUN after 1 cycle.
  - RUN stays in RUN until a pixel is accepted at column IMG_W-1, then goes to DRAIN.
  - DRAIN goes to DONE if the row counter was IMG_H-1, else to CLR.
  - DONE → IDLE after 1 cycle.
- Accept = pix_valid && pix_ready. Counters r (row) and c (column) reset to 0 on start. On accept, c increments and wraps at IMG_W-1, and r then increments.
- Line buffers lb[k][x], with k = 0..K_H-2 and x = 0..IMG_W-1, are 8-bit. On accept at (r,c):
  - for k < K_H-2: lb[k][c] ← lb[k+1][c]
  - lb[K_H-2][c] ← pix_data
- Registered on accept (at the next edge):
  - col_data[k] ← lb[k][c] for k < K_H-1
  - col_data[K_H-1] ← pix_data
  - load_en ← (r ≥ K_H-1)
  - win_valid ← (r ≥ K_H-1 && c ≥ K_W-1)
  - win_row ← r-(K_H-1)
  - win_col ← c-(K_W-1)
- load_en and win_valid are 0 in every cycle that does not follow an accept. col_data holds its value otherwise.
- Rows 0..K_H-2 only fill the line buffers; they produce no load_en.
- Line-buffer contents are not reset. Stale data is never emitted because the first K_H-1 rows overwrite every entry before any load_en.
- Windows per frame: (IMG_H-K_H+1)·(IMG_W-K_W+1).

## Timing
- Latency: pixel accepted at edge T → load_en / col_data / win_valid high during cycle T+1.
- Row boundary: last pixel of a row accepted at T.
  - T+1 is DRAIN: last load_en, pix_ready=0.
  - T+2 is CLR: clear=1, pix_ready=0.
  - T+3 is RUN again.
  - clear is never high in the same cycle as load_en.
- Frame start: start at T → CLR in T+1 → first possible accept in T+2.
- Frame end: DRAIN then DONE (frame_done=1), then IDLE.
- pix_valid bubbles are allowed anywhere in RUN. The FSM waits and counters hold.
- start while busy is ignored.
- Reset values:
  - state IDLE, r = c = 0
  - pix_ready, load_en, clear, win_valid, busy, frame_done = 0
  - col_data, win_row, win_col = 0
- rst mid-frame: the next cycle shows all reset values. Any partially loaded window is abandoned, and a fresh start is required.

## Test plan
- Reset → all outputs 0 and pix_ready=0. A pix_valid stream in IDLE is not accepted.
- Parameters IMG_W=5, IMG_H=4, K=3; pixel = 16r+c, streamed back-to-back:
  - first load_en follows accept of (2,0), with col_data = {0x00,0x10,0x20}
  - first win_valid follows accept of (2,2), with win_row=0, win_col=0
  - exactly 10 load_en and 6 win_valid per frame
  - frame_done 2 cycles after the final accept
- Row boundary, same setup: after each row's last accept, pix_ready is low for exactly 2 cycles. clear is high only in the second, and never overlaps load_en.
- Random pix_valid gaps (~50%) → identical col_data / win_row / win_col sequence to the back-to-back run.
- start pulsed mid-frame → ignored, frame completes normally. rst asserted after 9 accepts → outputs return to reset values next cycle. A new start then yields a correct full frame.
- Default parameters (28×28, K=3) → 676 win_valid pulses. The last has win_row=25, win_col=25 and col_data = {pix(25,27), pix(26,27), pix(27,27)}.
